prog_sequencer: RTL
===================

# prog_sequencer

Program-level controller for the core's fetch stage: it starts a selected program and tracks it to completion. On a start request it holds the program counter in load/init, drives the selected program's base address, releases the core to run, and waits for the core's halt. It then reports completion with a cycle count. It sits between the testbench/top-level start–done handshake and the fetch stage's init and PC-load inputs, and replaces ad-hoc per-program start sequencing inside the fetch stage.

## Interface
Parameters:
- NUM_PROGS, 3: number of selectable programs.
- PC_W, 10: program counter width.
- INIT_CYCLES, 2: cycles init/pc_load is held before run is released (≥1).
- MAX_CYCLES, 16'd60000: RUN-cycle watchdog limit.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  level request; a rising value sampled in IDLE launches a program.
- prog_sel  in  2  program index, sampled with start.
- halt  in  1  core halt indication from decode.
- init  out  1  holds the fetch stage and state in init.
- pc_load_val  out  PC_W  base address for the fetch stage while init=1.
- run  out  1  core enable.
- busy  out  1  high in INIT and RUN.
- done  out  1  completion level.
- timeout  out  1  valid with done: program hit MAX_CYCLES.
- bad_sel  out  1  one-cycle pulse: start with prog_sel ≥ NUM_PROGS.
- cycle_count  out  16  RUN cycles of the last or current program.

## Operation
- States: IDLE, INIT, RUN, DONE.
- IDLE:
  - start=1 with a valid prog_sel: latch sel, clear cycle_count and timeout, go to INIT.
  - start=1 with an invalid prog_sel: pulse bad_sel, stay in IDLE.
- INIT:
  - init=1, run=0, pc_load_val=PROG_BASE[sel].
  - A down-counter runs INIT_CYCLES cycles, then the block goes to RUN.
  - halt is ignored.
- RUN:
  - run=1, init=0, cycle_count increments each cycle.
  - halt=1: go to DONE. The halting cycle is counted.
  - cycle_count reaching MAX_CYCLES: set timeout, go to DONE.
  - halt and limit in the same cycle: DONE with timeout=0 (halt wins).
- DONE:
  - done=1, run=0, init=0.
  - cycle_count and timeout hold.
  - start=0 returns the block to IDLE. done remains high until then (four-phase handshake).
- start, when it is not acting as a request, is ignored in INIT and RUN. prog_sel changes after launch have no effect.
- cycle_count saturates at 16'hFFFF and never wraps.
- pc_load_val in states other than INIT is 0.

## Timing
- Reset (async, any state): state=IDLE. init=0, run=0, busy=0, done=0, timeout=0, bad_sel=0, cycle_count=0, pc_load_val=0.
- Reset asserted mid-RUN drops run immediately, without waiting for a clock.
- All outputs are decoded from registered state and counters (Moore). No combinational input-to-output path.
- Launch sequence:
  - start is sampled at edge t.
  - init=1 for edges t+1 … t+INIT_CYCLES.
  - run=1 from edge t+INIT_CYCLES+1.
- Completion sequence:
  - halt is sampled at edge h in RUN.
  - done=1 and run=0 after edge h.
  - cycle_count equals the number of RUN edges up to and including h.
- Release: start=0 sampled in DONE returns the block to IDLE at the next edge. A fresh start needs one IDLE cycle with start sampled high.

## Structure
- Package prog_pkg holds:
  - state_t enum (IDLE, INIT, RUN, DONE);
  - PROG_BASE array of PC_W-bit base addresses: 0, 219, 220;
  - widths for cycle_count and sel.
- Sub-module sat_counter (parameterised width, clear/enable, saturating) is used for cycle_count. The INIT counter stays inline.

## Test plan
- Reset, then start=1, sel=1, halt after 5 RUN cycles -> init=1 for 2 cycles with pc_load_val=219; run=1 for 5 cycles; done=1, cycle_count=5, timeout=0.
- Back-to-back: sel=0, halt; start low for 1 cycle; then sel=2 -> second run shows pc_load_val=220; cycle_count restarts from 0.
- start=1, sel=3 -> bad_sel pulses 1 cycle; state stays IDLE; init never asserts.
- Bench with MAX_CYCLES=10 and halt never asserted -> done after 10 RUN cycles, timeout=1, cycle_count=10. With halt on cycle 10 -> timeout=0.
- Reset pulsed mid-RUN, between edges -> run, busy and cycle_count go to 0 immediately. A subsequent start behaves as from power-up.
- halt held high during INIT and start held high in DONE -> halt is ignored in INIT; the block stays in DONE until start drops.

Source files
------------

// File: rtl/prog_sequencer_pkg.sv
// Shared types and constants for the program sequencer.
// Holds the controller state encoding, the per-program base address table,
// and the widths of the selector and cycle counter.
package prog_sequencer_pkg;

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

  localparam int BASE_W  = 10;
  localparam int SEL_W   = 2;
  localparam int COUNT_W = 16;

  localparam logic [BASE_W-1:0] PROG_BASE [3] = '{10'd0, 10'd219, 10'd220};

  // Selectors outside the table map to address 0 so the lookup is total.
  function automatic logic [BASE_W-1:0] progBase(input logic [SEL_W-1:0] sel);
    logic [BASE_W-1:0] base;
    base = '0;
    case (sel)
      2'd0:    base = PROG_BASE[0];
      2'd1:    base = PROG_BASE[1];
      2'd2:    base = PROG_BASE[2];
      default: base = '0;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Start/done handshake and fetch-stage control bundle of the program sequencer.
// master: the requester side (drives start, prog_sel, halt).
// slave:  the sequencer side (drives init, pc_load_val, run, status outputs).
interface prog_sequencer_if #(
  parameter int PC_W = 10
);
  logic            start;
  logic [1:0]      prog_sel;
  logic            halt;
  logic            init;
  logic [PC_W-1:0] pc_load_val;
  logic            run;
  logic            busy;
  logic            done;
  logic            timeout;
  logic            bad_sel;
  logic [15:0]     cycle_count;

  modport master (
    output start, prog_sel, halt,
    input  init, pc_load_val, run, busy, done, timeout, bad_sel, cycle_count
  );

  modport slave (
    input  start, prog_sel, halt,
    output init, pc_load_val, run, busy, done, timeout, bad_sel, cycle_count
  );
endinterface

// File: rtl/prog_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Ports: clk, rst (async, active-high), clear_i, en_i, count_o.
// Clear has priority over enable; the count sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next value: clear wins, otherwise step unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/prog_sequencer.sv
// Program-level controller for the fetch stage: launches the selected
// program (init + base address), releases the core, waits for halt or the
// watchdog limit, then reports completion over a four-phase handshake.
// Ports: clk, rst (async, active-high), bus (prog_sequencer_if.slave):
//   in  start, prog_sel, halt
//   out init, pc_load_val, run, busy, done, timeout, bad_sel, cycle_count
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int          NUM_PROGS   = 3,
  parameter int          PC_W        = 10,
  parameter int          INIT_CYCLES = 2,
  parameter logic [15:0] MAX_CYCLES  = 16'd60000
) (
  input logic               clk,
  input logic               rst,
  prog_sequencer_if.slave   bus
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [COUNT_W:0] LIMIT = {1'b0, MAX_CYCLES};

  state_t             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic [INIT_W-1:0]  initCnt_q;
  logic               init_q;
  logic               run_q;
  logic               busy_q;
  logic               done_q;
  logic               timeout_q;
  logic               badSel_q;
  logic [COUNT_W-1:0] cycleCount;
  logic               selValid;
  logic               launch;
  logic               limitReached;

  assign selValid = ({30'd0, bus.prog_sel} < 32'(NUM_PROGS));
  assign launch   = (state_q == IDLE) && bus.start && selValid;

  // The counter is about to take its value for this RUN edge, so compare
  // count+1 against the limit to stop exactly on the MAX_CYCLES-th edge.
  assign limitReached = ({1'b0, cycleCount} + 17'd1) >= LIMIT;

  sat_counter #(.WIDTH(COUNT_W)) u_cycleCounter (
    .clk     (clk),
    .rst     (rst),
    .clear_i (launch),
    .en_i    (state_q == RUN),
    .count_o (cycleCount)
  );

  // Controller FSM with registered control outputs. bad_sel defaults low so
  // it only survives one cycle after an invalid request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      initCnt_q <= '0;
      init_q    <= 1'b0;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      badSel_q  <= 1'b0;
    end else begin
      badSel_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (selValid) begin
              sel_q     <= bus.prog_sel;
              timeout_q <= 1'b0;
              initCnt_q <= INIT_W'(INIT_CYCLES - 1);
              init_q    <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= INIT;
            end else begin
              badSel_q <= 1'b1;
            end
          end
        end
        INIT: begin
          if (initCnt_q == '0) begin
            init_q  <= 1'b0;
            run_q   <= 1'b1;
            state_q <= RUN;
          end else begin
            initCnt_q <= initCnt_q - INIT_W'(1);
          end
        end
        RUN: begin
          // halt takes priority so a program halting on the limit edge
          // is reported as a clean finish.
          if (bus.halt || limitReached) begin
            timeout_q <= !bus.halt;
            run_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (!bus.start) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.init        = init_q;
  assign bus.run         = run_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
  assign bus.bad_sel     = badSel_q;
  assign bus.cycle_count = cycleCount;
  assign bus.pc_load_val = (state_q == INIT) ? PC_W'(progBase(sel_q)) : '0;

endmodule
